// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU: default width, control bundle
// and the named control encodings for the common operations.
package alu_pkg;

    localparam int ALU_WIDTH = 16;

    typedef struct packed {
        logic zero_lhs;
        logic invert_lhs;
        logic zero_rhs;
        logic invert_rhs;
        logic opcode;
        logic invert_result;
    } alu_ctrl_t;

    // zl il zr ir op inv
    localparam alu_ctrl_t ALU_SUB   = 6'b010011;
    localparam alu_ctrl_t ALU_ADD   = 6'b000010;
    localparam alu_ctrl_t ALU_AND   = 6'b000000;
    localparam alu_ctrl_t ALU_OR    = 6'b010101;
    localparam alu_ctrl_t ALU_ZERO  = 6'b101010;
    localparam alu_ctrl_t ALU_ONE   = 6'b111111;
    localparam alu_ctrl_t ALU_M_ONE = 6'b111010;
    localparam alu_ctrl_t ALU_INC   = 6'b011111;

endpackage

// File: rtl/alu_operand_cond.sv
// Operand conditioning: optional zeroing followed by optional inversion.
// Ports: zero_i, invert_i controls; data_i operand in; data_o conditioned.
module alu_operand_cond #(
    parameter int WIDTH = 16
) (
    input  logic             zero_i,
    input  logic             invert_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] zeroed;

    // Zero always precedes invert, so zero+invert gives all-ones.
    assign zeroed = zero_i ? '0 : data_i;
    assign data_o = invert_i ? ~zeroed : zeroed;

endmodule

// File: rtl/alu.sv
// Execute ALU: conditioned operands are ANDed or added, optionally inverted,
// and registered with one cycle of latency. Optional status flags are
// enabled with ALU_STATUS_FLAGS_EN (otherwise flag_zero/flag_neg read 0).
// Ports: clk, rst_n, in_valid, six control bits, lhs, rhs -> result,
// out_valid, flag_zero, flag_neg.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             zero_lhs,
    input  logic             invert_lhs,
    input  logic             zero_rhs,
    input  logic             invert_rhs,
    input  logic             opcode,
    input  logic             invert_result,
    input  logic [WIDTH-1:0] lhs,
    input  logic [WIDTH-1:0] rhs,
    output logic [WIDTH-1:0] result,
    output logic             out_valid,
    output logic             flag_zero,
    output logic             flag_neg
);

    alu_ctrl_t        ctrl;
    logic [WIDTH-1:0] x2;
    logic [WIDTH-1:0] y2;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] result_d;
    logic [WIDTH-1:0] result_q;
    logic             valid_q;

    assign ctrl = '{
        zero_lhs:      zero_lhs,
        invert_lhs:    invert_lhs,
        zero_rhs:      zero_rhs,
        invert_rhs:    invert_rhs,
        opcode:        opcode,
        invert_result: invert_result
    };

    alu_operand_cond #(.WIDTH(WIDTH)) u_lhs_cond (
        .zero_i   (ctrl.zero_lhs),
        .invert_i (ctrl.invert_lhs),
        .data_i   (lhs),
        .data_o   (x2)
    );

    alu_operand_cond #(.WIDTH(WIDTH)) u_rhs_cond (
        .zero_i   (ctrl.zero_rhs),
        .invert_i (ctrl.invert_rhs),
        .data_i   (rhs),
        .data_o   (y2)
    );

    // Carry-out is dropped; the sum wraps modulo 2^WIDTH.
    assign r        = ctrl.opcode ? (x2 + y2) : (x2 & y2);
    assign result_d = ctrl.invert_result ? ~r : r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                result_q <= result_d;
            end
        end
    end

    assign result    = result_q;
    assign out_valid = valid_q;

`ifdef ALU_STATUS_FLAGS_EN
    logic zero_q;
    logic neg_q;

    // Flags follow the final (post-invert) value, same hold rule as result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else if (in_valid) begin
            zero_q <= (result_d == '0);
            neg_q  <= result_d[WIDTH-1];
        end
    end

    assign flag_zero = zero_q;
    assign flag_neg  = neg_q;
`else
    assign flag_zero = 1'b0;
    assign flag_neg  = 1'b0;
`endif

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases, back-to-back handshake,
// async reset, and randomized traffic against an arithmetic reference model.
module tb_alu;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [5:0]  ctl;
    logic [15:0] lhs;
    logic [15:0] rhs;
    logic [15:0] result;
    logic        out_valid;
    logic        flag_zero;
    logic        flag_neg;

    int total = 0;
    int bad   = 0;

    localparam logic [5:0] C_SUB  = 6'b010011;
    localparam logic [5:0] C_ADD  = 6'b000010;
    localparam logic [5:0] C_AND  = 6'b000000;
    localparam logic [5:0] C_OR   = 6'b010101;
    localparam logic [5:0] C_ZERO = 6'b101010;
    localparam logic [5:0] C_ONE  = 6'b111111;
    localparam logic [5:0] C_M1   = 6'b111010;
    localparam logic [5:0] C_INC  = 6'b011111;

    alu #(.WIDTH(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .zero_lhs      (ctl[5]),
        .invert_lhs    (ctl[4]),
        .zero_rhs      (ctl[3]),
        .invert_rhs    (ctl[2]),
        .opcode        (ctl[1]),
        .invert_result (ctl[0]),
        .lhs           (lhs),
        .rhs           (rhs),
        .result        (result),
        .out_valid     (out_valid),
        .flag_zero     (flag_zero),
        .flag_neg      (flag_neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: bitwise NOT of a 16-bit value is 65535 - value.
    function automatic logic [15:0] model(logic [5:0] c, logic [15:0] a,
                                          logic [15:0] b);
        int unsigned m = 65535;
        int unsigned x;
        int unsigned y;
        int unsigned r;
        x = c[5] ? 0 : int'(a);
        if (c[4]) x = m - x;
        y = c[3] ? 0 : int'(b);
        if (c[2]) y = m - y;
        r = c[1] ? (x + y) % 65536 : (x & y);
        if (c[0]) r = m - r;
        return r[15:0];
    endfunction

    function automatic logic exp_fz(logic [15:0] v);
`ifdef ALU_STATUS_FLAGS_EN
        return v == 16'd0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic exp_fn(logic [15:0] v);
`ifdef ALU_STATUS_FLAGS_EN
        return v >= 16'd32768;
`else
        return 1'b0;
`endif
    endfunction

    // Drive one valid op at a negedge, then return at the next negedge
    // with in_valid dropped.
    task automatic issue(logic [5:0] c, logic [15:0] a, logic [15:0] b);
        @(negedge clk);
        ctl = c; lhs = a; rhs = b; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; ctl = '0; lhs = '0; rhs = '0;
        repeat (2) @(negedge clk);
        total++;
        if (result !== 16'd0 || out_valid !== 1'b0 ||
            flag_zero !== 1'b0 || flag_neg !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: res=%h ov=%b fz=%b fn=%b want 0",
                     result, out_valid, flag_zero, flag_neg);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [5:0]  cs [8];
        logic [15:0] as [8];
        logic [15:0] bs [8];
        logic [15:0] ws [8];
        cs = '{C_SUB, C_ADD, C_AND, C_OR, C_M1, C_ONE, C_ZERO, C_INC};
        as = '{16'd20, 16'hFFFF, 16'hF0F0, 16'hF0F0,
               16'h1234, 16'hABCD, 16'h5555, 16'h7FFF};
        bs = '{16'd5, 16'd1, 16'h3C3C, 16'h3C3C,
               16'h9876, 16'h4321, 16'hAAAA, 16'h0003};
        ws = '{16'd15, 16'h0000, 16'h3030, 16'hFCFC,
               16'hFFFF, 16'h0001, 16'h0000, 16'h8000};
        for (int i = 0; i < 8; i++) begin
            issue(cs[i], as[i], bs[i]);
            total++;
            if (result !== ws[i] || out_valid !== 1'b1 ||
                flag_zero !== exp_fz(ws[i]) || flag_neg !== exp_fn(ws[i]))
            begin
                bad++;
                $display("FAIL directed_%0d: res=%h ov=%b fz=%b fn=%b want %h 1 %b %b",
                         i, result, out_valid, flag_zero, flag_neg, ws[i],
                         exp_fz(ws[i]), exp_fn(ws[i]));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a [3];
        logic [15:0] w;
        int          hi = 0;
        a = '{16'd100, 16'd200, 16'd300};
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            ctl = C_INC; lhs = a[i]; rhs = 16'h0BAD; in_valid = 1'b1;
            @(negedge clk);
            w = a[i] + 16'd1;
            if (out_valid === 1'b1) hi++;
            total++;
            if (result !== w) begin
                bad++;
                $display("FAIL b2b_res_%0d: res=%h want %h", i, result, w);
            end
        end
        in_valid = 1'b0; lhs = 16'h1111;
        @(negedge clk);
        total++;
        if (hi != 3 || out_valid !== 1'b0 || result !== 16'd301) begin
            bad++;
            $display("FAIL b2b_idle: hi=%0d ov=%b res=%h want 3 0 012d",
                     hi, out_valid, result);
        end
    endtask

    task automatic test_async_reset();
        issue(C_ADD, 16'h1200, 16'h0034);
        total++;
        if (result !== 16'h1234) begin
            bad++;
            $display("FAIL pre_reset: res=%h want 1234", result);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (result !== 16'd0 || out_valid !== 1'b0 ||
            flag_zero !== 1'b0 || flag_neg !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: res=%h ov=%b fz=%b fn=%b want 0",
                     result, out_valid, flag_zero, flag_neg);
        end
        @(negedge clk);
        rst_n = 1'b1;
        issue(C_SUB, 16'd5, 16'd7);
        total++;
        if (result !== 16'hFFFE || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL post_reset: res=%h ov=%b want fffe 1",
                     result, out_valid);
        end
    endtask

    task automatic test_random();
        logic [15:0] e_res = '0;
        logic        e_ov  = 1'b0;
        logic        v;
        for (int i = 0; i <= 300; i++) begin
            @(negedge clk);
            if (i > 0) begin
                total++;
                if (result !== e_res || out_valid !== e_ov ||
                    flag_zero !== exp_fz(e_res) ||
                    flag_neg !== exp_fn(e_res)) begin
                    bad++;
                    $display("FAIL rand_%0d: res=%h ov=%b fz=%b fn=%b want %h %b %b %b",
                             i, result, out_valid, flag_zero, flag_neg,
                             e_res, e_ov, exp_fz(e_res), exp_fn(e_res));
                end
            end
            if (i == 300) break;
            v = (i == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            ctl = 6'($urandom);
            lhs = 16'($urandom);
            rhs = 16'($urandom);
            in_valid = v;
            if (v) e_res = model(ctl, lhs, rhs);
            e_ov = v;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
